mux4_rr_sched: RTL
==================

MUX4_RR_SCHED -- requirements
Module: mux4_rr_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each requester data word.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  4  per-requester request; bit i = requester i.
REQ-005 SHALL have port in_data  input  4*DATA_W  requester words packed; requester i at bits [i*DATA_W +: DATA_W].
REQ-006 SHALL have port in_ready  output  4  one-hot acceptance pulse to the winning requester.
REQ-007 SHALL have port out_valid  output  1  output register holds a word.
REQ-008 SHALL have port out_data  output  DATA_W  registered selected word.
REQ-009 SHALL have port out_ready  input  1  downstream acceptance.
REQ-010 SHALL have port grant_sel  output  2  index of requester whose word is in the output register.
REQ-011 SHALL have port in_last  input  4  end-of-packet flag per requester; used only when MUX_SCHED_LOCK_EN is defined, otherwise ignored.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (output empty) and HOLD (output full).
REQ-013 In IDLE with any in_valid bit set, SHALL pick a winner by round-robin, searching from index ptr upward modulo 4; the first set bit wins.
REQ-014 In IDLE on a win, SHALL assert in_ready[winner] combinationally in that cycle only, capture in_data[winner] into out_data, load grant_sel=winner, and enter HOLD next cycle.
REQ-015 In IDLE with in_valid==0, SHALL keep in_ready=0 and remain in IDLE.
REQ-016 In HOLD, SHALL drive out_valid=1, keep out_data and grant_sel stable, keep in_ready=0.
REQ-017 In HOLD with out_ready=1, SHALL complete the transfer, set ptr=(grant_sel+1) mod 4 (wrap 3->0), and return to IDLE next cycle.
REQ-018 In HOLD with out_ready=0, SHALL remain in HOLD indefinitely; in_valid changes SHALL NOT affect outputs.
REQ-019 Latency: requester accept to out_valid = 1 cycle; maximum throughput one word per 2 cycles.
REQ-020 Fairness: a continuously valid requester SHALL win within 4 arbitrations.
REQ-021 out_valid SHALL be registered; in_ready SHALL depend only on state, ptr and in_valid.

Reset
REQ-022 On rst=1 at a clock edge: state=IDLE, ptr=0, out_valid=0, out_data=0, grant_sel=0; in_ready=0 while rst is high.
REQ-023 Reset in HOLD SHALL discard the held word without a transfer; reset overrides a simultaneous out_ready.

Configuration
REQ-024 Macro MUX_SCHED_LOCK_EN SHALL enable packet lock: if a transferred word had in_last[grant_sel]=0 when captured, the next arbitration considers only requester grant_sel and ptr is not advanced; lock releases after a word with in_last=1 completes.
REQ-025 While locked, other requesters SHALL get in_ready=0 even if the locked requester is idle.
REQ-026 Without MUX_SCHED_LOCK_EN, every word is arbitrated independently, no lock state is synthesized, and in_last is unused.
REQ-027 Reset SHALL clear the lock.

Structure
REQ-028 Shared package mux_sched_pkg SHALL hold NUM_REQ=4, SEL_W=2 and the FSM state enum (IDLE, HOLD).
REQ-029 Data selection SHALL use the team's existing mux4to1 sub-module, one instance per data bit (DATA_W instances), sel=winner index.

Verification
REQ-030 Reset: assert rst two cycles in HOLD -> out_valid=0, out_data=0, grant_sel=0, in_ready=0 on next cycle.
REQ-031 Single requester: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100 one cycle, next cycle out_valid=1, out_data=8'hA5, grant_sel=2.
REQ-032 Round-robin: in_valid=4'b1111 constant, out_ready=1 -> grant_sel sequence 0,1,2,3,0 on successive transfers.
REQ-033 Backpressure: word 8'h3C held, out_ready=0 for 5 cycles while in_valid toggles -> out_data stays 8'h3C, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034 Wrap: ptr=3 after grant 2, in_valid=4'b1001 -> requester 3 wins, then requester 0.
REQ-035 Lock (MUX_SCHED_LOCK_EN defined): requester 1 sends 3 words, in_last=0,0,1, requester 2 valid throughout -> grants 1,1,1 then 2; without macro -> grants 1,2,1,2.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared definitions for the 4-input round-robin scheduler: requester count,
// select width, FSM state encoding and the round-robin search helper.
package mux_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Returns {found, index} of the first set request at or after start, wrapping.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [SEL_W-1:0]   start);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = start + SEL_W'(k);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux4to1.sv
// Single-bit 4-to-1 multiplexer used to build the scheduler's data path.
module mux4to1 (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic [1:0] sel,
  output logic       y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Four-requester round-robin scheduler with a single-word output register.
// Optional packet lock is enabled by defining MUX_SCHED_LOCK_EN.
module mux4_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic [NUM_REQ-1:0]        in_last,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          grant_sel
);

  state_t            state;
  state_t            next_state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  winner;
  logic              win;
  logic [SEL_W:0]    pick;
  logic [DATA_W-1:0] sel_data;

`ifdef MUX_SCHED_LOCK_EN
  logic locked;
  logic held_last;
`else
  logic unused_last;
  assign unused_last = ^in_last;
`endif

  assign pick = rr_pick(in_valid, ptr);

  // While a packet is locked only the previous grantee may be considered.
  always_comb begin
    win    = pick[SEL_W];
    winner = pick[SEL_W-1:0];
`ifdef MUX_SCHED_LOCK_EN
    if (locked) begin
      win    = in_valid[grant_sel];
      winner = grant_sel;
    end
`endif
  end

  always_comb begin
    next_state = state;
    in_ready   = '0;
    case (state)
      IDLE: begin
        if (win && !rst) begin
          in_ready   = NUM_REQ'(1) << winner;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    mux4to1 u_mux (
      .d0  (in_data[b]),
      .d1  (in_data[DATA_W + b]),
      .d2  (in_data[2*DATA_W + b]),
      .d3  (in_data[3*DATA_W + b]),
      .sel (winner),
      .y   (sel_data[b])
    );
  end

  // Capture on acceptance; release and advance the pointer on downstream transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_sel <= '0;
`ifdef MUX_SCHED_LOCK_EN
      locked    <= 1'b0;
      held_last <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (win) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            grant_sel <= winner;
`ifdef MUX_SCHED_LOCK_EN
            held_last <= in_last[winner];
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef MUX_SCHED_LOCK_EN
            if (!held_last) begin
              locked <= 1'b1;
            end else begin
              locked <= 1'b0;
              ptr    <= grant_sel + SEL_W'(1);
            end
`else
            ptr <= grant_sel + SEL_W'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
